ex_forward_ctrl: RTL and testbench
==================================

# ex_forward_ctrl

Decode-stage forwarding and load-use control that produces the registered 2-bit ForwardA/ForwardB select codes consumed by the EX-stage operand muxes. Keeps its own two-deep shadow of in-flight destination registers (EX, MEM). Resolves each decoded instruction's rs/rt against the shadow one cycle early, so the select codes reach EX aligned with the ID/EX pipeline register. Also raises a one-cycle stall for load-use hazards.

## Interface
- NREG, 32: architectural register count; register index width is $clog2(NREG).
- clk  in  1: pipeline clock, rising edge.
- rst_n  in  1: synchronous, active-low reset.
- id_valid  in  1: ID holds a real instruction.
- id_rs, id_rt  in  5: source register indices.
- id_use_rs, id_use_rt  in  1: the instruction actually reads rs / rt.
- id_dest  in  5: destination register index.
- id_reg_write  in  1: the instruction writes id_dest.
- id_mem_read  in  1: the instruction is a load.
- flush  in  1: kill the ID instruction (branch or jump resolved).
- stall  out  1: hold PC and IF/ID, inject a bubble; combinational.
- ForwardA, ForwardB  out  2: EX operand select, registered. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data.
- stall_count  out  16: saturating load-use stall count (FWD_STALL_CNT_EN only).

## Operation
- Shadow records: ex_rec and mem_rec, each holding {valid, dest, reg_write, mem_read}. Every cycle mem_rec <= ex_rec and ex_rec <= the incoming record.
- Incoming record:
  - The ID fields when id_valid && !flush && !stall.
  - Otherwise a bubble (valid=0).
- A record is a producer only if valid && reg_write && dest != 0. Register 0 is never forwarded and never stalls.
- Per operand (rs with use_rs, rt with use_rt), evaluated at ID:
  - If it matches an ex_rec producer that is a load: hazard.
  - Else if it matches an ex_rec producer: select 01.
  - Else if it matches a mem_rec producer: select 10.
  - Else: select 00.
  - ex_rec has priority over mem_rec, because it is the newer producer.
- stall = id_valid && !flush && (hazard on rs || hazard on rt).
- ForwardA/ForwardB register the computed selects when an instruction enters, and load 00 on a bubble.
- After a stall cycle the load has moved to mem_rec. The re-evaluated operand then selects 10.
- The register file is write-before-read, so a WB-stage producer needs no forwarding.
- Simultaneous flush and hazard: flush wins, stall=0, a bubble is inserted.

## Timing
- Reset (rst_n=0 at a rising edge): ex_rec and mem_rec invalid, ForwardA=ForwardB=00, stall_count=0. stall is 0 while the records are invalid.
- Forward codes are valid one cycle after the instruction is presented at ID, the same edge at which ID/EX captures it.
- stall depends combinationally on ID inputs and ex_rec in the same cycle. A load-use stall lasts exactly one cycle per hazard.
- Reset asserted mid-stall clears the records. stall drops in the same cycle, because ex_rec is invalid after the edge.
- There is no inbound stall from later stages. Records shift every cycle.

## Configuration
- FWD_STALL_CNT_EN defined:
  - stall_count increments on each clock where stall=1.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and its counter are absent.

## Structure
- Package fwd_pkg holds:
  - Constants FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The stage-record struct type {valid, dest, reg_write, mem_read}.
- Sub-module fwd_src_sel: combinational per-operand compare against the two records, producing {sel[1:0], hazard}. It is instantiated twice, for rs and rt.

## Test plan
- add r3 at ID, then sub using rs=r3 in the next cycle -> ForwardA=01 one cycle later, no stall.
- add r3, nop, then or rt=r3 -> ForwardB=10.
- lw r5, then add rs=r5 -> stall=1 for one cycle; ex_rec bubble; next cycle ForwardA=10; stall_count=1.
- add r4 followed immediately by addi r4, then use r4 -> ForwardA=01 (newest producer wins, not 10).
- Writer to r0, then a reader of r0 -> ForwardA=00, no stall.
- Load-use hazard with flush=1 in the same cycle -> stall=0; bubble inserted; ForwardA/B=00 next cycle. Reset mid-stall -> all outputs 00/0 after the edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and the in-flight stage record used by the forwarding control.
package fwd_pkg;

  localparam int unsigned FWD_NREG = 32;
  localparam int unsigned FWD_RW   = $clog2(FWD_NREG);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [FWD_RW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } stage_rec_t;

  localparam stage_rec_t FWD_BUBBLE = '{valid: 1'b0, dest: '0, reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand compare of one source index against the EX and MEM shadow records.
module fwd_src_sel
  import fwd_pkg::*;
(
  input  logic [FWD_RW-1:0] src_i,
  input  logic              use_i,
  input  stage_rec_t        ex_rec_i,
  input  logic              mem_valid_i,
  input  logic [FWD_RW-1:0] mem_dest_i,
  input  logic              mem_reg_write_i,
  output logic [1:0]        sel_o,
  output logic              hazard_o
);

  logic ex_prod;
  logic mem_prod;
  logic ex_hit;
  logic mem_hit;

  // Register 0 is hard-wired, so a producer targeting it is ignored.
  assign ex_prod  = ex_rec_i.valid && ex_rec_i.reg_write && (ex_rec_i.dest != '0);
  assign mem_prod = mem_valid_i && mem_reg_write_i && (mem_dest_i != '0);
  assign ex_hit   = use_i && ex_prod && (ex_rec_i.dest == src_i);
  assign mem_hit  = use_i && mem_prod && (mem_dest_i == src_i);

  always_comb begin
    sel_o    = FWD_REGFILE;
    hazard_o = 1'b0;
    if (ex_hit) begin
      if (ex_rec_i.mem_read) hazard_o = 1'b1;
      else                   sel_o    = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// Decode-stage forwarding select and load-use stall generation.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module ex_forward_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rs,
  input  logic [$clog2(NREG)-1:0] id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic [$clog2(NREG)-1:0] id_dest,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    flush,
  output logic                    stall,
`ifdef FWD_STALL_CNT_EN
  output logic [15:0]             stall_count,
`endif
  output logic [1:0]              ForwardA,
  output logic [1:0]              ForwardB
);

  stage_rec_t ex_rec_q, ex_rec_d;
  stage_rec_t mem_rec_q;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic [1:0] sel_a, sel_b;
  logic       haz_a, haz_b;
  logic       id_live;
  logic       enter;

  fwd_src_sel u_sel_rs (
    .src_i           (id_rs),
    .use_i           (id_use_rs),
    .ex_rec_i        (ex_rec_q),
    .mem_valid_i     (mem_rec_q.valid),
    .mem_dest_i      (mem_rec_q.dest),
    .mem_reg_write_i (mem_rec_q.reg_write),
    .sel_o           (sel_a),
    .hazard_o        (haz_a)
  );

  fwd_src_sel u_sel_rt (
    .src_i           (id_rt),
    .use_i           (id_use_rt),
    .ex_rec_i        (ex_rec_q),
    .mem_valid_i     (mem_rec_q.valid),
    .mem_dest_i      (mem_rec_q.dest),
    .mem_reg_write_i (mem_rec_q.reg_write),
    .sel_o           (sel_b),
    .hazard_o        (haz_b)
  );

  // Flush dominates a hazard: the killed instruction must not stall the front end.
  assign id_live = id_valid && !flush;
  assign stall   = id_live && (haz_a || haz_b);
  assign enter   = id_live && !stall;

  always_comb begin
    ex_rec_d = FWD_BUBBLE;
    fwd_a_d  = FWD_REGFILE;
    fwd_b_d  = FWD_REGFILE;
    if (enter) begin
      ex_rec_d.valid     = 1'b1;
      ex_rec_d.dest      = id_dest;
      ex_rec_d.reg_write = id_reg_write;
      ex_rec_d.mem_read  = id_mem_read;
      fwd_a_d            = sel_a;
      fwd_b_d            = sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rec_q  <= FWD_BUBBLE;
      mem_rec_q <= FWD_BUBBLE;
      fwd_a_q   <= FWD_REGFILE;
      fwd_b_q   <= FWD_REGFILE;
    end else begin
      mem_rec_q <= ex_rec_q;
      ex_rec_q  <= ex_rec_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  assign ForwardA = fwd_a_q;
  assign ForwardB = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Randomized and directed checks of ex_forward_ctrl against a pipeline-history model.
module tb_ex_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic       flush;
  logic       stall;
  logic [1:0] ForwardA, ForwardB;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  always #5 clk = ~clk;

  ex_forward_ctrl #(.NREG(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
`ifdef FWD_STALL_CNT_EN
    .stall_count  (stall_count),
`endif
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: the two most recent things that left ID, newest first.
  typedef struct {
    bit v;
    int d;
    bit w;
    bit ld;
  } rec_t;

  rec_t hist[2];
  int   m_fa, m_fb, m_cnt;
  logic last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 3 = load-use hazard, otherwise the select code.
  function automatic int operand(input int r, input bit u);
    if (!u || r == 0) return 0;
    if (hist[0].v && hist[0].w && hist[0].d == r) return hist[0].ld ? 3 : 1;
    if (hist[1].v && hist[1].w && hist[1].d == r) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
    m_fa = 0;
    m_fb = 0;
    m_cnt = 0;
  endtask

  task automatic apply(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit w, input bit ld, input bit fl, input bit rn);
    int  sa, sb;
    bit  es, en;
    id_valid     = v;
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_dest      = 5'(dest);
    id_reg_write = w;
    id_mem_read  = ld;
    flush        = fl;
    rst_n        = rn;
    #3;
    sa = operand(rs, urs);
    sb = operand(rt, urt);
    es = v && !fl && (sa == 3 || sb == 3);
    last_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, es});
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (es && m_cnt != 16'hFFFF) m_cnt++;
      en = v && !fl && !es;
      hist[1] = hist[0];
      hist[0] = en ? '{1, dest, w, ld} : '{0, 0, 0, 0};
      m_fa = en ? sa : 0;
      m_fb = en ? sb : 0;
    end
    #1;
    chk("ForwardA", {30'd0, ForwardA}, m_fa);
    chk("ForwardB", {30'd0, ForwardB}, m_fb);
`ifdef FWD_STALL_CNT_EN
    chk("stall_count", {16'd0, stall_count}, m_cnt);
`endif
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_fwdA", {30'd0, ForwardA}, 0);
    chk("rst_fwdB", {30'd0, ForwardB}, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_stall", {31'd0, stall}, 0);

    // add r3 ; sub rs=r3
    apply(1, 1, 2, 1, 1, 3, 1, 0, 0, 1);
    apply(1, 3, 4, 1, 1, 6, 1, 0, 0, 1);
    chk("tp_exmem_A", {30'd0, ForwardA}, 1);
    chk("tp_exmem_nostall", {31'd0, last_stall}, 0);

    // add r3 ; nop ; or rt=r3
    do_reset();
    apply(1, 1, 2, 1, 1, 3, 1, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 7, 3, 1, 1, 8, 1, 0, 0, 1);
    chk("tp_memwb_B", {30'd0, ForwardB}, 2);

    // lw r5 ; add rs=r5 (stall, then re-presented)
    do_reset();
    apply(1, 1, 0, 1, 0, 5, 1, 1, 0, 1);
    apply(1, 5, 2, 1, 1, 9, 1, 0, 0, 1);
    chk("tp_lu_stall", {31'd0, last_stall}, 1);
    chk("tp_lu_bubbleA", {30'd0, ForwardA}, 0);
    apply(1, 5, 2, 1, 1, 9, 1, 0, 0, 1);
    chk("tp_lu_restall", {31'd0, last_stall}, 0);
    chk("tp_lu_memwbA", {30'd0, ForwardA}, 2);
`ifdef FWD_STALL_CNT_EN
    chk("tp_lu_count", {16'd0, stall_count}, 1);
`endif

    // add r4 ; addi r4 ; use r4
    do_reset();
    apply(1, 1, 2, 1, 1, 4, 1, 0, 0, 1);
    apply(1, 4, 0, 1, 0, 4, 1, 0, 0, 1);
    apply(1, 4, 0, 1, 0, 10, 1, 0, 0, 1);
    chk("tp_newest_A", {30'd0, ForwardA}, 1);

    // writer r0 ; reader r0 (load, to also rule out a stall)
    do_reset();
    apply(1, 1, 2, 1, 1, 0, 1, 1, 0, 1);
    apply(1, 0, 0, 1, 1, 11, 1, 0, 0, 1);
    chk("tp_r0_nostall", {31'd0, last_stall}, 0);
    chk("tp_r0_A", {30'd0, ForwardA}, 0);
    chk("tp_r0_B", {30'd0, ForwardB}, 0);

    // load-use with flush
    do_reset();
    apply(1, 1, 2, 1, 1, 5, 1, 1, 0, 1);
    apply(1, 5, 5, 1, 1, 12, 1, 0, 1, 1);
    chk("tp_flush_nostall", {31'd0, last_stall}, 0);
    chk("tp_flush_A", {30'd0, ForwardA}, 0);
    chk("tp_flush_B", {30'd0, ForwardB}, 0);

    // reset mid-stall
    apply(1, 1, 2, 1, 1, 6, 1, 1, 0, 1);
    apply(1, 6, 0, 1, 0, 13, 1, 0, 0, 0);
    chk("tp_rst_stall_was", {31'd0, last_stall}, 1);
    chk("tp_rst_A", {30'd0, ForwardA}, 0);
    apply(1, 6, 0, 1, 0, 13, 1, 0, 0, 1);
    chk("tp_rst_cleared", {31'd0, last_stall}, 0);
    chk("tp_rst_after_A", {30'd0, ForwardA}, 0);

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(9, 0) != 0,
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            int'($urandom_range(3, 0)),
            $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
            $urandom_range(9, 0) == 0, $urandom_range(99, 0) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
